mips_data_responder: RTL and testbench
======================================

Name: mips_data_responder

Overview:
- Memory-side responder for the single-cycle core's data port.
- Decodes the core's `memwrite` / `aluout` / `writedata` and returns `readdata` in the same cycle.
- Contains a word-addressed data RAM, a byte-wide transmit FIFO drained over a valid/ready handshake, and a free-running cycle timer.
- Sits between the `mips` top-level data port and the external output consumer.

Parameters:
- RAM_AW, 6, word-address width of data RAM (RAM holds 2**RAM_AW 32-bit words).
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  write strobe from core; write commits at the next rising clk.
- aluout  in  32  byte address from core; bits [1:0] ignored.
- writedata  in  32  store data from core.
- readdata  out  32  load data to core; combinational from `aluout` and current state.
- out_data  out  8  FIFO head byte; 8'h00 when FIFO empty.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head byte.

Behaviour:
- Address map (decode on `aluout`):
  - `aluout[31]==0` → RAM, word index `aluout[RAM_AW+1:2]`; upper bits aliased.
  - `32'hFFFF_0000` TXDATA.
  - `32'hFFFF_0004` STATUS.
  - `32'hFFFF_0008` TIMER.
  - Any other address with `aluout[31]==1`: read 0, write ignored.
- RAM:
  - Asynchronous read.
  - Synchronous write when `memwrite`.
  - Contents not cleared by reset.
- TXDATA:
  - Write pushes `writedata[7:0]` if FIFO not full.
  - If full and no pop that cycle, byte is dropped and sticky `overflow` is set.
  - Reads return 0.
- STATUS read value:
  - bit0 = empty.
  - bit1 = full.
  - bit2 = overflow.
  - bits [15:8] = occupancy count, zero-extended.
  - All other bits 0.
- STATUS write: `writedata[2]==1` clears `overflow`; all other bits ignored.
- TIMER:
  - 32-bit counter, +1 every cycle; wraps `FFFF_FFFF`→0.
  - Write loads `writedata`, and the load wins over the increment in that cycle.
  - Read returns the current value.
- FIFO pop: occurs on a rising edge with `out_valid && out_ready`; head advances.
- Simultaneous push and pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: `out_valid` is 0, so no pop; push accepted.
- Latency:
  - A byte written in cycle N appears on `out_data`/`out_valid` after edge N.
  - A STATUS read in the same cycle as the write shows pre-write state.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Reset (async assert, any time, including mid-handshake):
  - FIFO pointers and count → 0, so `out_valid`=0 and `out_data`=8'h00.
  - `overflow`=0.
  - TIMER=0.
  - `readdata` reflects the reset state immediately (e.g. STATUS reads `32'h1`).
  - RAM is untouched.
- `memwrite` with `aluout[1:0]!=0` behaves as the aligned word.

Decomposition:
- Package `mips_mmio_pkg`:
  - Address constants ADDR_TXDATA, ADDR_STATUS, ADDR_TIMER.
  - STATUS bit indices ST_EMPTY, ST_FULL, ST_OVF, and the count field LSB.
- Sub-module `byte_fifo`:
  - Parameter DEPTH.
  - Ports clk, reset, push, din, pop, dout, empty, full, count.
- The top level holds the decode, RAM, timer, overflow flag and the readdata mux.

Test Plan:
- Reset, then read STATUS → readdata=`32'h0000_0001`, out_valid=0, out_data=`8'h00`; TIMER reads 0 then 1 one cycle later.
- Write `32'h1234_5678` to `32'h0000_0010`, then read `32'h0000_0010` and alias `32'h0000_0110` (RAM_AW=6) → both return `32'h1234_5678`; read `32'hFFFF_0010` → 0.
- With out_ready=0, write bytes 1..8 to TXDATA, then write 9 → STATUS=`32'h0000_0806` (full, overflow, count 8). Raise out_ready → bytes 1..8 drained in order, one per cycle, then out_valid=0 and STATUS=`32'h0000_0005`.
- FIFO full with out_ready=1, write `8'hAA` to TXDATA in the same cycle → count stays 8, overflow stays 0, `8'hAA` is the last byte drained.
- Write TIMER=`32'hFFFF_FFFE` → reads `FFFF_FFFE` next cycle, then `FFFF_FFFF`, then `0000_0000`.
- Assert reset mid-drain with 3 bytes queued and out_ready=1 → out_valid drops asynchronously, STATUS reads `32'h1`, and a RAM word written earlier reads its prior value.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// Shared address map and STATUS layout for the core's data-port responder.
package mips_mmio_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_0008;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    // Byte offset within the word is irrelevant to every register in the map.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with async active-low reset; head byte reads as 0 when empty.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign dout  = empty ? 8'h00 : r_mem[r_rptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_data_responder.sv
// Data-port responder: word RAM, transmit byte FIFO, cycle timer and
// a combinational readdata mux back to the single-cycle core.
module mips_data_responder
    import mips_mmio_pkg::*;
#(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [2**RAM_AW];
    logic [31:0]       r_timer;
    logic              r_ovf;

    logic [31:0]       w_word;
    logic              w_is_ram;
    logic              w_is_tx;
    logic              w_is_status;
    logic              w_is_timer;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_tx_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [7:0]        w_head;
    logic [31:0]       w_status;

    assign w_word      = word_addr(aluout);
    assign w_is_ram    = !aluout[31];
    assign w_is_tx     = (w_word == ADDR_TXDATA);
    assign w_is_status = (w_word == ADDR_STATUS);
    assign w_is_timer  = (w_word == ADDR_TIMER);
    assign w_ram_idx   = aluout[RAM_AW+1:2];

    assign w_tx_push = memwrite && w_is_tx;
    assign w_pop     = out_valid && out_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tx_push),
        .din   (writedata[7:0]),
        .pop   (w_pop),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    assign out_valid = !w_empty;
    assign out_data  = w_head;

    // RAM has no reset so software-visible contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (memwrite && w_is_ram) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (memwrite && w_is_timer) begin
                r_timer <= writedata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_tx_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (memwrite && w_is_status && writedata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[ST_EMPTY]             = w_empty;
        w_status[ST_FULL]              = w_full;
        w_status[ST_OVF]               = r_ovf;
        w_status[ST_COUNT_LSB +: 8]    = 8'(w_count);
    end

    always_comb begin
        readdata = '0;
        if (w_is_ram) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_is_status) begin
            readdata = w_status;
        end else if (w_is_timer) begin
            readdata = r_timer;
        end
    end

endmodule

// File: tb/tb_mips_data_responder.sv
// Scenario bench for mips_data_responder with a byte scoreboard on the FIFO.
module tb_mips_data_responder;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_TMR = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int          checks;
    int          errors;
    logic [7:0]  q[$];
    logic        m_ovf;

    mips_data_responder #(
        .RAM_AW     (6),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] r;
        r        = '0;
        r[0]     = (q.size() == 0);
        r[1]     = (q.size() == 8);
        r[2]     = m_ovf;
        r[15:8]  = 8'(q.size());
        return r;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        memwrite = 1'b0;
        aluout   = a;
        #1;
        d = readdata;
    endtask

    // Only used while out_ready is low, so the model never sees a pop here.
    task automatic tx_write(input logic [7:0] b);
        bus_write(A_TX, {24'h0, b});
        if (q.size() < 8) q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic drain(input int budget);
        int         n;
        bit         done;
        logic [7:0] e;
        n    = 0;
        done = 0;
        @(negedge clk);
        memwrite  = 1'b0;
        aluout    = A_ST;
        out_ready = 1'b1;
        while (!done) begin
            #1;
            checks++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra got %h expected no byte", out_data);
                    done = 1;
                end else begin
                    e = q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL drain_byte got %h expected %h", out_data, e);
                    end
                end
            end else begin
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL drain_stall got out_valid=0 expected %0d more bytes", q.size());
                end
                done = 1;
            end
            n++;
            if (!done && n > budget) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout got %0d cycles expected <= %0d", n, budget);
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        out_ready = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        memwrite  = 1'b0;
        aluout    = '0;
        writedata = '0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        aluout = A_ST;
        #1;
        checks++;
        if (readdata !== 32'h0000_0001) begin
            errors++; $display("FAIL reset_status got %h expected %h", readdata, 32'h1);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out got v=%b d=%h expected v=0 d=00", out_valid, out_data);
        end
        aluout = A_TMR;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_timer0 got %h expected 0", readdata);
        end
        begin
            logic [31:0] rd;
            bus_read(A_TMR, rd);
            checks++;
            if (rd !== 32'h1) begin
                errors++; $display("FAIL reset_timer1 got %h expected 1", rd);
            end
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        bus_write(32'h0000_0010, 32'h1234_5678);
        bus_read(32'h0000_0010, rd);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_read got %h expected 12345678", rd);
        end
        bus_read(32'h0000_0110, rd);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_alias got %h expected 12345678", rd);
        end
        bus_read(32'hFFFF_0010, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h expected 0", rd);
        end
        bus_write(32'h0000_0023, 32'hAABB_CCDD);
        bus_read(32'h0000_0020, rd);
        checks++;
        if (rd !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL ram_unaligned got %h expected aabbccdd", rd);
        end
        bus_read(A_TX, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL txdata_read got %h expected 0", rd);
        end
    endtask

    task automatic test_overflow_drain();
        logic [31:0] rd;
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) tx_write(8'(i));
        bus_read(A_ST, rd);
        checks++;
        if (rd !== 32'h0000_0806 || exp_status() !== 32'h0000_0806) begin
            errors++; $display("FAIL status_full_ovf got %h expected 00000806", rd);
        end
        drain(20);
        bus_read(A_ST, rd);
        checks++;
        if (rd !== 32'h0000_0005) begin
            errors++; $display("FAIL status_after_drain got %h expected 00000005", rd);
        end
        bus_write(A_ST, 32'h0000_0004);
        m_ovf = 1'b0;
        bus_read(A_ST, rd);
        checks++;
        if (rd !== exp_status()) begin
            errors++; $display("FAIL status_ovf_clear got %h expected %h", rd, exp_status());
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e;
        for (int i = 1; i <= 8; i++) tx_write(8'(8'h10 + i));
        @(negedge clk);
        memwrite  = 1'b1;
        aluout    = A_TX;
        writedata = 32'h0000_00AA;
        out_ready = 1'b1;
        #1;
        e = q.pop_front();
        q.push_back(8'hAA);
        checks++;
        if (out_data !== e) begin
            errors++; $display("FAIL fullpp_head got %h expected %h", out_data, e);
        end
        @(negedge clk);
        memwrite  = 1'b0;
        out_ready = 1'b0;
        aluout    = A_ST;
        #1;
        checks++;
        if (readdata !== exp_status()) begin
            errors++; $display("FAIL fullpp_status got %h expected %h", readdata, exp_status());
        end
        drain(20);
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFE;
        exp[1] = 32'hFFFF_FFFF;
        exp[2] = 32'h0000_0000;
        bus_write(A_TMR, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            bus_read(A_TMR, rd);
            checks++;
            if (rd !== exp[i]) begin
                errors++; $display("FAIL timer_wrap%0d got %h expected %h", i, rd, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] e;
        bus_write(32'h0000_0040, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) tx_write(8'(8'hC0 + i));
        @(negedge clk);
        memwrite  = 1'b0;
        aluout    = A_ST;
        out_ready = 1'b1;
        #1;
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            errors++; $display("FAIL middrain_head got v=%b d=%h expected v=1 d=%h", out_valid, out_data, e);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL middrain_out got v=%b d=%h expected v=0 d=00", out_valid, out_data);
        end
        checks++;
        if (readdata !== exp_status()) begin
            errors++; $display("FAIL middrain_status got %h expected %h", readdata, exp_status());
        end
        aluout = 32'h0000_0040;
        #1;
        checks++;
        if (readdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL middrain_ram got %h expected cafef00d", readdata);
        end
        aluout = A_TMR;
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL middrain_timer got %h expected 0", readdata);
        end
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ram();
        test_overflow_drain();
        test_full_push_pop();
        test_timer();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
